// File: rtl/req_vec_serializer_if.sv
// rtl/req_vec_serializer_if.sv - mask-in / index-out handshake bundle for req_vec_serializer
// Ports (interface signals):
//   in_valid, in_ready, in_mask[WIDTH]        : request mask input handshake
//   out_valid, out_ready, out_idx[IDX_W], out_last : index output handshake
//   stat_masks[CNT_W], stat_idx[CNT_W]        : statistics counters (block -> observer)
// Modports: slave = serializer side, master = producer/consumer/observer side.
interface req_vec_serializer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic [CNT_W-1:0] stat_masks;
  logic [CNT_W-1:0] stat_idx;

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_idx, out_last, stat_masks, stat_idx
  );

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_idx, out_last, stat_masks, stat_idx
  );
endinterface

// File: rtl/req_vec_serializer.sv
// rtl/req_vec_serializer.sv - serializes a request mask into set-bit indices, lowest first
// Ports:
//   ck   : clock, all state on posedge ck
//   rst  : synchronous active-high reset, priority over everything
//   bus  : req_vec_serializer_if.slave (in_* mask handshake, out_* index handshake, stat_*)
// Optional feature macro: REQ_VEC_SERIALIZER_STATS_EN enables saturating stat counters;
// when undefined, stat_masks/stat_idx are tied to zero and no counter flops exist.
module req_vec_serializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input logic                ck,
  input logic                rst,
  req_vec_serializer_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;

  logic             out_valid;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;
  logic             in_ready;
  logic             accept;
  logic             beat;

  // Lowest set bit index; 0 for an empty mask.
  function automatic logic [IDX_W-1:0] find_first1(input logic [WIDTH-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // State register
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == DRAIN);
    out_idx   = find_first1(mask_q);
    // Only one bit left when clearing the lowest set bit empties the mask.
    out_last  = out_valid & ((mask_q & (mask_q - WIDTH'(1))) == '0);
    // Accept a new mask on the final beat so back-to-back masks stream without a bubble.
    in_ready  = (state_q == IDLE) | (out_valid & out_last & bus.out_ready);
    accept    = bus.in_valid & in_ready;
    beat      = out_valid & bus.out_ready;

    bus.out_valid = out_valid;
    bus.out_idx   = out_idx;
    bus.out_last  = out_last;
    bus.in_ready  = in_ready;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    if (beat) begin
      mask_d = mask_q & (mask_q - WIDTH'(1));
      if (out_last) state_d = IDLE;
    end
    if (accept) begin
      if (bus.in_mask != '0) begin
        mask_d  = bus.in_mask;
        state_d = DRAIN;
      end else begin
        // Empty mask is swallowed without producing a beat.
        state_d = IDLE;
      end
    end
  end

`ifdef REQ_VEC_SERIALIZER_STATS_EN
  logic [CNT_W-1:0] stat_masks_q, stat_masks_d;
  logic [CNT_W-1:0] stat_idx_q, stat_idx_d;

  always_comb begin
    stat_masks_d = stat_masks_q;
    stat_idx_d   = stat_idx_q;
    if (accept && (bus.in_mask != '0) && (stat_masks_q != '1))
      stat_masks_d = stat_masks_q + CNT_W'(1);
    if (beat && (stat_idx_q != '1))
      stat_idx_d = stat_idx_q + CNT_W'(1);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      stat_masks_q <= '0;
      stat_idx_q   <= '0;
    end else begin
      stat_masks_q <= stat_masks_d;
      stat_idx_q   <= stat_idx_d;
    end
  end

  assign bus.stat_masks = stat_masks_q;
  assign bus.stat_idx   = stat_idx_q;
`else
  assign bus.stat_masks = '0;
  assign bus.stat_idx   = '0;
`endif
endmodule

// File: tb/tb_req_vec_serializer.sv
// tb/tb_req_vec_serializer.sv - directed self-checking bench for req_vec_serializer
module tb_req_vec_serializer;
  logic ck;
  logic rst;
  int   checks;
  int   errors;

  req_vec_serializer_if #(.WIDTH(16), .CNT_W(16)) bus ();

  req_vec_serializer #(.WIDTH(16), .CNT_W(16)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic beat_chk(input string tag, input logic v, input int idx, input logic last);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    if (v) begin
      check({tag, "_idx"}, 32'(bus.out_idx), 32'(idx));
      check({tag, "_last"}, 32'(bus.out_last), 32'(last));
    end
  endtask

  int exp_idx_a[4] = '{0, 5, 10, 15};
  int stat_m_exp;
  int stat_i_exp;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_stat_masks", 32'(bus.stat_masks), 32'd0);
    check("rst_stat_idx", 32'(bus.stat_idx), 32'd0);

    // Empty mask: consumed, no beat
    bus.in_valid = 1'b1;
    bus.in_mask  = 16'h0000;
    #1;
    check("zero_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("zero_no_valid", 32'(bus.out_valid), 32'd0);
      check("zero_in_ready_after", 32'(bus.in_ready), 32'd1);
      tick();
    end

    // 16'h8421 with out_ready=1: 0,5,10,15
    bus.in_valid  = 1'b1;
    bus.in_mask   = 16'h8421;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat_chk("m8421", 1'b1, exp_idx_a[i], i == 3);
      tick();
    end
    check("m8421_idle_valid", 32'(bus.out_valid), 32'd0);
    check("m8421_idle_ready", 32'(bus.in_ready), 32'd1);

    // 16'h0006 with backpressure
    bus.in_valid  = 1'b1;
    bus.in_mask   = 16'h0006;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat_chk("m0006_hold", 1'b1, 1, 1'b0);
      check("m0006_hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    beat_chk("m0006_b0", 1'b1, 1, 1'b0);
    tick();
    beat_chk("m0006_b1", 1'b1, 2, 1'b1);
    check("m0006_last_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("m0006_idle_valid", 32'(bus.out_valid), 32'd0);

    // Back-to-back: 16'h0003 then 16'h0010 accepted on the last beat
    bus.in_valid = 1'b1;
    bus.in_mask  = 16'h0003;
    tick();
    bus.in_mask  = 16'h0010;
    #1;
    beat_chk("b2b_0", 1'b1, 0, 1'b0);
    check("b2b_0_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    beat_chk("b2b_1", 1'b1, 1, 1'b1);
    check("b2b_1_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    beat_chk("b2b_4", 1'b1, 4, 1'b1);
    tick();
    check("b2b_idle_valid", 32'(bus.out_valid), 32'd0);

    // 16'hFFFF, reset after first beat
    bus.in_valid = 1'b1;
    bus.in_mask  = 16'hFFFF;
    tick();
    bus.in_valid = 1'b0;
    beat_chk("ffff_b0", 1'b1, 0, 1'b0);
    tick();
    beat_chk("ffff_b1", 1'b1, 1, 1'b0);
`ifdef REQ_VEC_SERIALIZER_STATS_EN
    stat_m_exp = 5;
    stat_i_exp = 10;
`else
    stat_m_exp = 0;
    stat_i_exp = 0;
`endif
    check("mid_stat_masks", 32'(bus.stat_masks), 32'(stat_m_exp));
    check("mid_stat_idx", 32'(bus.stat_idx), 32'(stat_i_exp));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("ffff_rst_valid", 32'(bus.out_valid), 32'd0);
    check("ffff_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("ffff_rst_stat_masks", 32'(bus.stat_masks), 32'd0);
    check("ffff_rst_stat_idx", 32'(bus.stat_idx), 32'd0);
    tick();
    check("ffff_rst_stays_idle", 32'(bus.out_valid), 32'd0);

    // Statistics: three 16'h000F masks fully drained
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_mask  = 16'h000F;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        beat_chk("stat_beat", 1'b1, i, i == 3);
        tick();
      end
    end
`ifdef REQ_VEC_SERIALIZER_STATS_EN
    stat_m_exp = 3;
    stat_i_exp = 12;
`else
    stat_m_exp = 0;
    stat_i_exp = 0;
`endif
    check("stat_masks", 32'(bus.stat_masks), 32'(stat_m_exp));
    check("stat_idx", 32'(bus.stat_idx), 32'(stat_i_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
